// File: rtl/seq_div_sgn.sv
// seq_div_sgn: multi-cycle restoring divider that produces one quotient bit per clock.
// Requests and results both use valid/ready handshakes. Each request can be unsigned or
// signed (two's complement). Divide-by-zero and signed overflow (MIN / -1) are flagged.
//
// Build option: define DIV_SIGNED_EN to honour sgn. When it is undefined, every request
// is unsigned, ovf is tied to 0, and the latency does not change.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous, active-high reset
//   in_valid/in_ready   request handshake; in_ready is high only in idle
//   sgn, dvnd, dvsr     request mode and operands, sampled on accept
//   out_valid/out_ready result handshake; the result is held until out_ready
//   quo, rmd            quotient (rounded toward zero), remainder (takes the dividend sign)
//   dbz, ovf            divide-by-zero and signed-overflow flags, valid with out_valid
module seq_div_sgn #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sgn,
  input  logic [W-1:0] dvnd,
  input  logic [W-1:0] dvsr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quo,
  output logic [W-1:0] rmd,
  output logic         dbz,
  output logic         ovf
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam logic [W-1:0] Ones = '1;
  localparam logic [W-1:0] Min  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StPrep, StOp, StFix, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   rh_q, rh_d, rl_q, rl_d, d_q, d_d;
  logic [W-1:0]   quo_q, quo_d, rmd_q, rmd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           qneg_q, qneg_d, rneg_q, rneg_d;
  logic           zdet_q, zdet_d, odet_q, odet_d;
  logic           dbz_q, dbz_d, ovf_q, ovf_d;

  // Operand conditioning for the prep state
  logic           a_neg, b_neg, ovf_det;
  logic [W-1:0]   abs_a, abs_b;

`ifdef DIV_SIGNED_EN
  logic sgn_q, sgn_d;
  assign a_neg   = sgn_q & a_q[W-1];
  assign b_neg   = sgn_q & b_q[W-1];
  assign abs_a   = a_neg ? (W'(0) - a_q) : a_q;
  assign abs_b   = b_neg ? (W'(0) - b_q) : b_q;
  assign ovf_det = sgn_q & (a_q == Min) & (b_q == Ones);
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign a_neg      = 1'b0;
  assign b_neg      = 1'b0;
  assign abs_a      = a_q;
  assign abs_b      = b_q;
  assign ovf_det    = 1'b0;
`endif

  // One restoring step: shift {rh,rl} left, and subtract when the partial remainder fits
  logic [W:0]   rh_sh;
  logic         q_bit;
  logic [W-1:0] rh_sub;
  assign rh_sh  = {rh_q, rl_q[W-1]};
  assign q_bit  = rh_sh >= {1'b0, d_q};
  // rh_sh - d_q is always below 2^W when q_bit is set, so W bits hold the result
  assign rh_sub = rh_sh[W-1:0] - d_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rh_d    = rh_q;
    rl_d    = rl_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zdet_d  = zdet_q;
    odet_d  = odet_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
`ifdef DIV_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = dvnd;
          b_d     = dvsr;
`ifdef DIV_SIGNED_EN
          sgn_d   = sgn;
`endif
          state_d = StPrep;
        end
      end
      StPrep: begin
        rh_d    = '0;
        rl_d    = abs_a;
        d_d     = abs_b;
        qneg_d  = a_neg ^ b_neg;
        rneg_d  = a_neg;
        zdet_d  = (b_q == '0);
        odet_d  = ovf_det;
        cnt_d   = CW'(W);
        // A divide-by-zero skips the iterations and is resolved in the fix state
        state_d = (b_q == '0) ? StFix : StOp;
      end
      StOp: begin
        rh_d  = q_bit ? rh_sub : rh_sh[W-1:0];
        rl_d  = {rl_q[W-2:0], q_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = StFix;
      end
      StFix: begin
        if (zdet_q) begin
          quo_d = Ones;
          rmd_d = a_q;
          dbz_d = 1'b1;
          ovf_d = 1'b0;
        end else begin
          // MIN / -1 wraps back to MIN on its own here; only the flag is extra
          quo_d = qneg_q ? (W'(0) - rl_q) : rl_q;
          rmd_d = rneg_q ? (W'(0) - rh_q) : rh_q;
          dbz_d = 1'b0;
          ovf_d = odet_q;
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      rh_q    <= '0;
      rl_q    <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zdet_q  <= 1'b0;
      odet_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rh_q    <= rh_d;
      rl_q    <= rl_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zdet_q  <= zdet_d;
      odet_q  <= odet_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
`ifdef DIV_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quo       = quo_q;
  assign rmd       = rmd_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_div_sgn.sv
module tb_seq_div_sgn;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         sgn = 1'b0;
  logic [W-1:0] dvnd = '0;
  logic [W-1:0] dvsr = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quo, rmd;
  logic         dbz, ovf;

  seq_div_sgn #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sgn       (sgn),
    .dvnd      (dvnd),
    .dvsr      (dvsr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo       (quo),
    .rmd       (rmd),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] quo;
    logic [W-1:0] rmd;
    logic         dbz;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model written with plain integer division
  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ia, ib, q, r;
    logic ss;
`ifdef DIV_SIGNED_EN
    ss = s;
`else
    ss = 1'b0 & s;
`endif
    e = '0;
    if (b == '0) begin
      e.quo = '1;
      e.rmd = a;
      e.dbz = 1'b1;
    end else if (ss) begin
      ia    = int'($signed(a));
      ib    = int'($signed(b));
      q     = ia / ib;
      r     = ia % ib;
      e.quo = q[W-1:0];
      e.rmd = r[W-1:0];
      e.ovf = (a == 16'h8000) && (b == 16'hFFFF);
    end else begin
      e.quo = a / b;
      e.rmd = a % b;
    end
    return e;
  endfunction

  // Present a request at a negedge; returns #1 after the accepting edge
  task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    check_eq("in_ready_before_req", {31'd0, in_ready}, 32'd1);
    sgn      = s;
    dvnd     = a;
    dvsr     = b;
    in_valid = 1'b1;
    sb.push_back(model(s, a, b));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; counts edges until out_valid, then checks the result
  task automatic collect(input string tag);
    exp_t e;
    int   lat;
    bit   got;
    lat = 0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_quo"}, {16'd0, quo}, {16'd0, e.quo});
      check_eq({tag, "_rmd"}, {16'd0, rmd}, {16'd0, e.rmd});
      check_eq({tag, "_dbz"}, {31'd0, dbz}, {31'd0, e.dbz});
      check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
      check_eq({tag, "_lat"}, lat, e.dbz ? 32'd2 : W + 2);
      check_eq({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_eq({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    check_eq({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run(input string tag, input logic s, input logic [W-1:0] a,
                     input logic [W-1:0] b);
    send(s, a, b);
    collect(tag);
    release_out(tag);
  endtask

  logic [W-1:0] hq, hr;
  logic [W-1:0] ra, rb;
  logic         rs;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_quo", {16'd0, quo}, 32'd0);
    check_eq("rst_rmd", {16'd0, rmd}, 32'd0);
    check_eq("rst_flags", {30'd0, dbz, ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run("u100_7", 1'b0, 16'd100, 16'd7);
    run("s_m7_2", 1'b1, 16'hFFF9, 16'h0002);
    run("s_7_m2", 1'b1, 16'h0007, 16'hFFFE);
    run("s_min_m1", 1'b1, 16'h8000, 16'hFFFF);
    run("u_dbz", 1'b0, 16'h1234, 16'h0000);
    run("s_dbz", 1'b1, 16'h1234, 16'h0000);
    run("u_min_m1", 1'b0, 16'h8000, 16'hFFFF);
    run("u_max_1", 1'b0, 16'hFFFF, 16'h0001);
    run("s_m1_m1", 1'b1, 16'hFFFF, 16'hFFFF);

    // Result held under back-pressure while a new request waits
    send(1'b0, 16'd1000, 16'd3);
    collect("stall");
    hq = quo;
    hr = rmd;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      sgn      = 1'b0;
      dvnd     = 16'd55;
      dvsr     = 16'd5;
      @(posedge clk);
      #1;
      check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stall_ready", {31'd0, in_ready}, 32'd0);
      check_eq("stall_quo", {16'd0, quo}, {16'd0, hq});
      check_eq("stall_rmd", {16'd0, rmd}, {16'd0, hr});
    end
    @(negedge clk);
    out_ready = 1'b1;
    sb.push_back(model(1'b0, 16'd55, 16'd5));
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_eq("stall_back_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    collect("after_stall");
    release_out("after_stall");

    // Reset in the middle of the iterations aborts the request
    send(1'b0, 16'd5000, 16'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
    check_eq("abort_ready", {31'd0, in_ready}, 32'd1);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    run("u200_9", 1'b0, 16'd200, 16'd9);

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      if (i % 6 == 5) rb = 16'($urandom_range(1, 9));
      run("rand", rs, ra, rb);
    end

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
